// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//   Decoupled instruction-fetch front end. It issues word-aligned reads on a
//   req/gnt imem port and can keep up to MAX_OUT reads outstanding. Responses
//   return in order and land in a DEPTH-entry {pc, inst} prefetch FIFO, which
//   decode pops through valid/ready. A redirect flushes the FIFO and restarts
//   fetch at a new pc. Reads that are still in flight are counted in `discard`
//   and their responses are dropped when they arrive.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   redirect_i            flush and restart fetch at redirect_pc_i (bits[1:0] ignored)
//   imem_req_o/addr_o     read request and its word-aligned address
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i in-order read response
//   inst_valid_o/inst_o/pc_o  FIFO head (zeros while empty)
//   inst_ready_i          decode consumes the head
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int unsigned           XLEN     = 32,
    parameter int unsigned           DEPTH    = 4,
    parameter int unsigned           MAX_OUT  = 2,
    parameter logic [XLEN-1:0]       RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            inst_ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0] fetch_pc;
    logic            req_en;       // holds fetch off until the first edge after reset
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   discard;
    logic [OW-1:0]   out_next;
    logic [OW-1:0]   discard_next;

    // Tag FIFO: the pc of each outstanding read, in issue order.
    logic [XLEN-1:0] tag_mem [MAX_OUT];
    logic [TW-1:0]   tag_wr, tag_rd;

    // Prefetch FIFO. The pointers carry an extra wrap bit.
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic [PW:0]     wr_ptr, rd_ptr;
    logic [PW:0]     fifo_count;
    logic            fifo_empty, fifo_full;
    logic [31:0]     in_use;

    logic issue, resp, keep, push, pop;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
    endfunction

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);

    // Credits: queued entries plus outstanding reads whose data will be kept.
    // Stale reads do not reserve a slot because their data is never pushed.
    assign in_use = 32'(fifo_count) + 32'(outstanding) - 32'(discard);

    assign imem_req_o  = req_en && !redirect_i
                         && (outstanding < OW'(MAX_OUT))
                         && (in_use < 32'(DEPTH));
    assign imem_addr_o = fetch_pc;

    assign issue = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding cannot be matched to a tag, so it is ignored.
    assign resp  = imem_rvalid_i && (outstanding != '0);
    assign keep  = resp && (discard == '0) && !redirect_i;
    assign pop   = !fifo_empty && inst_ready_i && !redirect_i;
    assign push  = keep && (!fifo_full || pop);

    assign out_next = outstanding + OW'(issue) - OW'(resp);

    always_comb begin
        discard_next = discard;
        if (redirect_i)
            // Every read still in flight after this cycle is stale. This
            // includes reads that were already stale from earlier redirects.
            discard_next = outstanding - OW'(resp);
        else if (resp && (discard != '0))
            discard_next = discard - OW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            req_en      <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            req_en      <= 1'b1;
            outstanding <= out_next;
            discard     <= discard_next;

            if (redirect_i)
                fetch_pc <= redirect_pc_i & ~XLEN'(3);
            else if (issue)
                fetch_pc <= fetch_pc + XLEN'(4);

            if (issue) tag_wr <= tag_inc(tag_wr);
            if (resp)  tag_rd <= tag_inc(tag_rd);

            if (redirect_i) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage arrays have no reset. Reads are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (issue)
            tag_mem[tag_wr] <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr[PW-1:0]]   <= tag_mem[tag_rd];
            inst_mem[wr_ptr[PW-1:0]] <= imem_rdata_i;
        end
    end

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? '0 : inst_mem[rd_ptr[PW-1:0]];
    assign pc_o         = fifo_empty ? '0 : pc_mem[rd_ptr[PW-1:0]];

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        gnt = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        ready = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o),
        .inst_ready_i(ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rel0  = 0;
    int lat   = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents: each word is a fixed function of its address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    // ---------------- imem responder + logs ----------------
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; int cyc; } pop_t;
    mreq_t       pq[$];
    logic [31:0] issue_log[$];
    pop_t        pop_log[$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pq.delete();
                rvalid = 1'b0;
                rdata  = '0;
            end else begin
                cyc++;
                if (rvalid) void'(pq.pop_front());
                if (inst_valid_o && ready && !redirect)
                    pop_log.push_back('{pc_o, inst_o, cyc});
                if (imem_req_o && gnt) begin
                    issue_log.push_back(imem_addr_o);
                    pq.push_back('{imem_addr_o, cyc + lat - 1});
                end
                #1;
                if (rst_n && pq.size() > 0 && pq[0].due <= cyc) begin
                    rvalid = 1'b1;
                    rdata  = mem_fn(pq[0].addr);
                end else begin
                    rvalid = 1'b0;
                    rdata  = '0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Each in-flight read is a queue entry with a stale flag. The expected
    // FIFO contents are held in a plain queue.
    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } fe_t;
    fl_t         m_fl[$];
    fe_t         m_q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_started = 1'b0;

    function automatic bit model_req();
        int fresh;
        fresh = 0;
        foreach (m_fl[i]) if (!m_fl[i].stale) fresh++;
        return m_started && !redirect && (m_fl.size() < MAX_OUT)
               && ((m_q.size() + fresh) < DEPTH);
    endfunction

    initial begin
        bit  iss;
        fl_t f;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_fl.delete();
                m_pc      = RESET_PC;
                m_started = 1'b0;
            end else begin
                iss = model_req() && gnt;
                if (m_q.size() > 0 && ready && !redirect) void'(m_q.pop_front());
                if (rvalid && m_fl.size() > 0) begin
                    f = m_fl.pop_front();
                    if (!f.stale && !redirect) m_q.push_back('{f.pc, mem_fn(f.pc)});
                end
                if (redirect) begin
                    m_q.delete();
                    foreach (m_fl[i]) m_fl[i].stale = 1'b1;
                    m_pc = redirect_pc & ~32'h3;
                end
                if (iss) begin
                    m_fl.push_back('{m_pc, 1'b0});
                    m_pc = m_pc + 32'd4;
                end
                m_started = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req",   imem_req_o,   0);
                chk("rst_valid", inst_valid_o, 0);
                chk("rst_inst",  inst_o,       0);
                chk("rst_pc",    pc_o,         0);
            end else begin
                r = model_req();
                chk("req", imem_req_o, r);
                if (r) chk("addr", imem_addr_o, m_pc);
                chk("valid", inst_valid_o, m_q.size() > 0);
                if (m_q.size() > 0) begin
                    chk("inst", inst_o, m_q[0].inst);
                    chk("pc",   pc_o,   m_q[0].pc);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit rdy, input int l);
        rst_n = 1'b0; redirect = 1'b0; gnt = 1'b1; ready = rdy; lat = l;
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        rel0 = cyc;
        pop_log.delete();
        issue_log.delete();
    endtask

    initial begin
        int n, idx;
        bit found;
        logic [31:0] a;

        // 1) sequential fetch, 1-cycle memory
        do_reset(1'b1, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1); n++;
            if (inst_valid_o) break;
        end
        chk("first_valid_cycle", n, 3);
        step(6);
        chk("seq_pops", pop_log.size() >= 4, 1);
        if (pop_log.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("seq_pc",  pop_log[i].pc, 32'(4 * i));
                chk("seq_cyc", pop_log[i].cyc - rel0, 32'(4 + i));
            end
        chk("seq_inst0", pop_log[0].inst, 32'hA5A5_FFFF);

        // 2) decode stalled: the credit limit stops issue at 4 requests
        do_reset(1'b0, 1);
        step(12);
        chk("stall_issues", issue_log.size(), 4);
        for (int i = 0; i < 4 && i < issue_log.size(); i++)
            chk("stall_addr", issue_log[i], 32'(4 * i));
        chk("stall_req_low", imem_req_o, 0);
        ready = 1'b1;
        step(6);
        chk("drain_pops", pop_log.size() >= 4, 1);
        if (pop_log.size() >= 4)
            for (int i = 0; i < 4; i++) chk("drain_pc", pop_log[i].pc, 32'(4 * i));
        chk("resume_issue", issue_log.size() >= 5, 1);
        if (issue_log.size() >= 5) chk("resume_addr", issue_log[4], 32'd16);

        // 3) grant withheld for 5 cycles
        gnt = 1'b0;
        step(1);
        a = imem_addr_o;
        for (int i = 0; i < 5; i++) begin
            chk("nogrant_req",  imem_req_o,  1);
            chk("nogrant_addr", imem_addr_o, a);
            step(1);
        end
        chk("nogrant_empty", inst_valid_o, 0);
        gnt = 1'b1;
        step(3);

        // 4) redirect with outstanding reads and a non-empty FIFO
        do_reset(1'b0, 3);
        step(7);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        idx = issue_log.size();
        step(1);
        redirect = 1'b0;
        chk("redir_flush", inst_valid_o, 0);
        pop_log.delete();
        ready = 1'b1;
        step(15);
        chk("redir_issue", issue_log.size() > idx, 1);
        if (issue_log.size() > idx) chk("redir_first_addr", issue_log[idx], 32'h100);
        chk("redir_pops", pop_log.size() >= 2, 1);
        if (pop_log.size() >= 2) begin
            chk("redir_pop0", pop_log[0].pc, 32'h100);
            chk("redir_pop1", pop_log[1].pc, 32'h104);
        end

        // 5) redirect in the same cycle as a response and a pop
        do_reset(1'b1, 2);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (rvalid && inst_valid_o) begin found = 1'b1; break; end
        end
        chk("collide_found", found, 1);
        redirect = 1'b1; redirect_pc = 32'h200;
        step(1);
        redirect = 1'b0;
        chk("collide_flush", inst_valid_o, 0);
        pop_log.delete();
        step(10);
        chk("collide_pops", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) chk("collide_pop0", pop_log[0].pc, 32'h200);

        // 6) fetch address wraps past the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        idx = issue_log.size();
        step(1);
        redirect = 1'b0;
        pop_log.delete();
        step(10);
        chk("wrap_issues", issue_log.size() >= idx + 2, 1);
        if (issue_log.size() >= idx + 2) begin
            chk("wrap_addr0", issue_log[idx],     32'hFFFF_FFFC);
            chk("wrap_addr1", issue_log[idx + 1], 32'h0);
        end
        chk("wrap_pops", pop_log.size() >= 2, 1);
        if (pop_log.size() >= 2) begin
            chk("wrap_pop0", pop_log[0].pc, 32'hFFFF_FFFC);
            chk("wrap_pop1", pop_log[1].pc, 32'h0);
        end

        // 7) asynchronous reset mid-stream
        do_reset(1'b0, 3);
        step(7);
        chk("pre_rst_valid", inst_valid_o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_req",   imem_req_o,   0);
        chk("arst_valid", inst_valid_o, 0);
        chk("arst_inst",  inst_o,       0);
        chk("arst_pc",    pc_o,         0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        issue_log.delete();
        pop_log.delete();
        ready = 1'b1; lat = 1;
        step(6);
        chk("rerun_issue", issue_log.size() >= 1, 1);
        if (issue_log.size() >= 1) chk("rerun_addr0", issue_log[0], RESET_PC);
        chk("rerun_pops", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) chk("rerun_pop0", pop_log[0].pc, RESET_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
